// File: rtl/demux_1x4_stream_sched.sv
// Purpose : packet scheduler/router; steers whole packets of a valid/ready
//           stream to one of four channels (addressed or round-robin).
// Latency : 1 cycle from input accept to out_valid.
// Backpr. : in_ready drops only while the one-deep output buffer holds a
//           beat that its selected channel does not take. Readiness of the
//           other channels is ignored, and round-robin never skips a channel.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   mode            - 0 addressed (in_dest), 1 round-robin; taken on first beat
//   in_valid/ready  - input beat handshake; in_data, in_last, in_dest payload
//   out_valid[3:0]  - one-hot channel valid; out_ready[3:0] per-channel ready
//   out_data/last   - held beat, shared by all channels
//   busy            - packet open or output buffer full
//   stat_cnt[63:0]  - per-channel 16-bit fired-beat counters
//
// Optional: define DEMUX_SCHED_STATS_EN to build the saturating counters;
//           otherwise stat_cnt is tied to zero.
module demux_1x4_stream_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [1:0]       in_dest,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic [63:0]      stat_cnt
);

   typedef enum logic {IDLE, PKT} state_t;

   state_t     state_q, state_d;
   logic [1:0] rr_ptr;
   logic [1:0] lock_dest;
   logic       lock_rr;     // packet was started in round-robin mode
   logic [1:0] route;
   logic       pkt_rr;      // round-robin flag that applies to this beat
   logic       buf_full;
   logic       out_fire;
   logic       accept;

   assign buf_full = |out_valid;
   assign out_fire = |(out_valid & out_ready);
   assign in_ready = !buf_full || out_fire;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == PKT) || buf_full;

   // Next state and route selection. Inside a packet the locked route and the
   // locked mode apply, so mid-packet changes of mode/in_dest are invisible.
   always_comb begin
      state_d = state_q;
      route   = lock_dest;
      pkt_rr  = lock_rr;
      if (state_q == IDLE) begin
         route  = mode ? rr_ptr : in_dest;
         pkt_rr = mode;
      end
      if (accept) begin
         case (state_q)
            IDLE:    if (!in_last) state_d = PKT;
            PKT:     if (in_last)  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr    <= 2'd0;
         lock_dest <= 2'd0;
         lock_rr   <= 1'b0;
         out_valid <= 4'b0000;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept && state_q == IDLE) begin
            lock_dest <= route;
            lock_rr   <= mode;
         end
         if (accept && in_last && pkt_rr)
            rr_ptr <= rr_ptr + 2'd1;
         // A new beat overwrites a firing one in the same cycle: no bubble.
         if (accept) begin
            out_valid <= 4'b0001 << route;
            out_data  <= in_data;
            out_last  <= in_last;
         end else if (out_fire) begin
            out_valid <= 4'b0000;
         end
      end
   end

`ifdef DEMUX_SCHED_STATS_EN
   logic [15:0] cnt [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < 4; n++) cnt[n] <= 16'd0;
      end else begin
         for (int n = 0; n < 4; n++)
            if (out_valid[n] && out_ready[n] && cnt[n] != 16'hFFFF)
               cnt[n] <= cnt[n] + 16'd1;
      end
   end

   assign stat_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
   assign stat_cnt = 64'd0;
`endif

endmodule

// File: doc/demux_1x4_stream_sched.md
Name: demux_1x4_stream_sched

Overview:
Packet-level scheduler and router in front of the 1x4 demux datapath.
- Accepts a valid/ready stream of WIDTH-bit beats and steers each whole packet to one of four output channels.
- Channel selection is either addressed (per-packet destination field) or round-robin.
- A one-deep registered output stage decouples input and output handshakes.
- Sits between a single producer and four consumers, e.g. a fan-out stage for per-lane processing.

Parameters:
WIDTH, 8, data beat width in bits

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = addressed, 1 = round-robin; sampled only on a packet's first beat
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  WIDTH  input beat payload
in_last  input  1  marks final beat of packet
in_dest  input  2  destination channel (0..3); sampled only on a packet's first beat in addressed mode
out_valid  output  4  one-hot; bit n = beat valid on channel n; at most one bit set
out_ready  input  4  per-channel ready
out_data  output  WIDTH  payload shared by all channels; meaningful only where out_valid bit set
out_last  output  1  last flag of the held beat
busy  output  1  high while a packet is open or the output buffer is full
stat_cnt  output  64  per-channel beat counters, ch n at [16n+15:16n] (see Optional Feature)

Behaviour:
- Reset, synchronous, active-high: out_valid=0, out_data=0, out_last=0, route FSM=IDLE, rr_ptr=0, buffer empty, stat_cnt=0.
  - rst mid-packet discards the buffered beat and any route lock.
  - The next accepted beat is treated as a packet start.
- Definitions:
  - buf_full = |out_valid
  - out_fire = |(out_valid & out_ready)
  - in_ready = !buf_full || out_fire (combinational; pass-through at full rate)
  - accept = in_valid && in_ready
- Route FSM:
  - IDLE: no open packet.
    - On accept, the route is in_dest when mode=0, or rr_ptr when mode=1.
    - If in_last=1 (single-beat packet), stay IDLE.
    - Otherwise lock the route into lock_dest and go to PKT.
  - PKT: all accepted beats use lock_dest; in_dest and mode are ignored.
    - On accept with in_last=1, go to IDLE.
- rr_ptr advances by 1 (mod 4, 3 wraps to 0) on acceptance of a last beat while in round-robin mode.
  - It does not advance in addressed mode.
  - Round-robin does not skip non-ready channels; the buffer waits on the selected channel.
- Output stage:
  - On accept: out_data<=in_data, out_last<=in_last, out_valid<=one-hot(route).
  - Else on out_fire: out_valid<=0.
  - Else: hold out_valid, out_data and out_last stable.
- Latency: exactly 1 cycle from accept to out_valid. Throughput is 1 beat/cycle when the selected channel holds ready high.
- Readiness of non-selected channels has no effect.
- Simultaneous out_fire and accept in the same cycle: the new beat replaces the old one with no bubble.
- busy = (FSM==PKT) || buf_full.
- Mode change mid-packet has no effect until the next packet start.

Optional Feature:
DEMUX_SCHED_STATS_EN
- Defined: four 16-bit counters.
  - Counter n increments on out_fire on channel n.
  - Counters saturate at 16'hFFFF and clear only on rst.
  - Driven on stat_cnt.
- Undefined: counters are not built and stat_cnt is tied to 0.

Test Plan:
- Addressed mode, rst then 3-beat packet dest=2 (data 0xA1,0xA2,0xA3, last on third), out_ready=4'hF.
  - out_valid=4'b0100 on cycles 1-3 after each accept; data in order; out_last on 0xA3; busy falls after final fire.
- Round-robin mode, four single-beat packets back-to-back.
  - Routed to channels 0,1,2,3 in that order; rr_ptr then wraps so a fifth packet goes to channel 0.
- Mid-packet in_dest and mode changes: 4-beat packet started dest=1, then in_dest=3 and mode=1 on beats 2-4.
  - All 4 beats appear on channel 1 only; rr_ptr unchanged.
- Backpressure: out_ready[1]=0 for 5 cycles with a beat held for channel 1.
  - out_valid=4'b0010 and out_data stable; in_ready=0; other channels' ready ignored.
  - Beat fires on the first cycle out_ready[1]=1, with in_ready=1 in that cycle.
- rst asserted on beat 2 of an open 3-beat packet.
  - Next cycle: out_valid=0, busy=0.
  - Next beat (addressed, dest=0) is routed to channel 0 as a new packet.
- With DEMUX_SCHED_STATS_EN: 70000 beats fired to channel 3.
  - stat_cnt[63:48]=16'hFFFF; other counters 0.
  - Without the macro, stat_cnt=0 throughout.
